// File: rtl/mesi_isc_snoop_sched.sv
// mesi_isc_snoop_sched: round-robin broadcast scheduler that snoops all other ports, then enables the originator.
module mesi_isc_snoop_sched #(
  parameter int PORTS          = 4,
  parameter int PORTS_LOG2     = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORTS*MBUS_CMD_WIDTH-1:0]    mbus_cmd_i,
  input  logic [PORTS*ADDR_WIDTH-1:0]        mbus_addr_i,
  output logic [PORTS-1:0]                   mbus_ack_o,
  output logic [PORTS*CBUS_CMD_WIDTH-1:0]    cbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]              cbus_addr_o,
  input  logic [PORTS-1:0]                   cbus_ack_i,
  output logic                               broad_busy_o
);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = '0;
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, SNOOP, ENABLE} state_t;

  state_t                  state, state_nx;
  logic [PORTS-1:0]        full, wr, cap, pend, pend_nx;
  logic [ADDR_WIDTH-1:0]   slot_addr [PORTS];
  logic [PORTS_LOG2-1:0]   rr, orig, gnt;
  logic                    gnt_v, en_ack;

  for (genvar k = 0; k < PORTS; k++) begin : g_cap
    logic [MBUS_CMD_WIDTH-1:0] c;
    assign c = mbus_cmd_i[k*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
    assign cap[k] = (c == MBUS_WR_BROAD || c == MBUS_RD_BROAD) && !full[k] && !mbus_ack_o[k];
  end

  // Scan downward so the full slot closest at-or-after rr wins.
  always_comb begin
    int p;
    p = 0;
    gnt = '0;
    gnt_v = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      p = (int'(rr) + i) % PORTS;
      if (full[p]) begin
        gnt = PORTS_LOG2'(p);
        gnt_v = 1'b1;
      end
    end
  end

  assign pend_nx = pend & ~cbus_ack_i;
  assign en_ack  = state == ENABLE && cbus_ack_i[orig];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  always_comb
    state_nx = state == IDLE   ? (gnt_v ? SNOOP : IDLE) :
               state == SNOOP  ? (pend_nx == '0 ? ENABLE : SNOOP) :
               state == ENABLE ? (en_ack ? IDLE : ENABLE) : IDLE;

  always_comb begin
    cbus_cmd_o = '0;
    for (int j = 0; j < PORTS; j++)
      cbus_cmd_o[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
        state == SNOOP && pend[j] ? (wr[orig] ? CBUS_WR_SNOOP : CBUS_RD_SNOOP) :
        state == ENABLE && orig == PORTS_LOG2'(j) ? (wr[orig] ? CBUS_EN_WR : CBUS_EN_RD) : CBUS_NOP;
    broad_busy_o = state != IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full        <= '0;
      mbus_ack_o  <= '0;
      pend        <= '0;
      rr          <= '0;
      orig        <= '0;
      cbus_addr_o <= '0;
    end else begin
      mbus_ack_o <= cap;
      for (int k = 0; k < PORTS; k++)
        if (cap[k]) full[k] <= 1'b1;
      if (state == IDLE && gnt_v) begin
        orig        <= gnt;
        cbus_addr_o <= slot_addr[gnt];
        pend        <= ~(PORTS'(1) << gnt);
      end
      if (state == SNOOP) pend <= pend_nx;
      if (en_ack) begin
        full[orig] <= 1'b0;
        rr         <= orig == PORTS_LOG2'(PORTS - 1) ? '0 : orig + 1'b1;
      end
    end

  // Slot payload is only meaningful while full, so it needs no reset.
  always_ff @(posedge clk)
    for (int k = 0; k < PORTS; k++)
      if (cap[k]) begin
        wr[k]        <= mbus_cmd_i[k*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] == MBUS_WR_BROAD;
        slot_addr[k] <= mbus_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
endmodule

// File: tb/tb_mesi_isc_snoop_sched.sv
// tb_mesi_isc_snoop_sched: directed checks of capture, round-robin grant, snoop/enable sequencing and reset.
module tb_mesi_isc_snoop_sched;
  logic         clk = 1'b0, rst = 1'b0;
  logic [11:0]  mbus_cmd = '0;
  logic [127:0] mbus_addr = '0;
  logic [3:0]   mbus_ack;
  logic [11:0]  cbus_cmd;
  logic [31:0]  cbus_addr;
  logic [3:0]   cbus_ack = '0;
  logic         busy;
  int           n_cmp = 0, n_bad = 0;

  mesi_isc_snoop_sched dut (
    .clk(clk), .rst(rst),
    .mbus_cmd_i(mbus_cmd), .mbus_addr_i(mbus_addr), .mbus_ack_o(mbus_ack),
    .cbus_cmd_o(cbus_cmd), .cbus_addr_o(cbus_addr), .cbus_ack_i(cbus_ack),
    .broad_busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int p, input logic [2:0] c, input logic [31:0] a);
    mbus_cmd[p*3 +: 3]   = c;
    mbus_addr[p*32 +: 32] = a;
  endtask

  function automatic logic [11:0] pk(input logic [2:0] c3, input logic [2:0] c2,
                                     input logic [2:0] c1, input logic [2:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic serve(input int o, input logic [2:0] en, input string tag);
    cbus_ack = 4'hf & ~(4'(1) << o);
    tick;
    chk({tag, "_en"}, cbus_cmd, 12'(en) << (3 * o));
    cbus_ack = 4'(1) << o;
    tick;
    cbus_ack = '0;
    chk({tag, "_nop"}, cbus_cmd, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [2:0] fv [4];
    fv = '{3'd1, 3'd2, 3'd5, 3'd7};
    tick;
    chk("rst_ack", mbus_ack, 0);
    chk("rst_cmd", cbus_cmd, 0);
    chk("rst_addr", cbus_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    // single WR_BROAD from port0
    req(0, 3'd3, 32'h1);
    tick;
    chk("t1_ack", mbus_ack, 4'b0001);
    chk("t1_busy0", busy, 0);
    req(0, 3'd0, 32'h0);
    tick;
    chk("t1_snoop", cbus_cmd, pk(1, 1, 1, 0));
    chk("t1_addr", cbus_addr, 32'h1);
    chk("t1_ack_pulse", mbus_ack, 0);
    chk("t1_busy1", busy, 1);
    serve(0, 3'd3, "t1");
    // staggered acks, plus an ignored ack on the originator
    req(0, 3'd4, 32'h5);
    tick;
    chk("t2_ack", mbus_ack, 4'b0001);
    req(0, 3'd0, 32'h0);
    tick;
    chk("t2_snoop", cbus_cmd, pk(2, 2, 2, 0));
    chk("t2_addr", cbus_addr, 32'h5);
    cbus_ack = 4'b0100;
    tick;
    chk("t2_ack2", cbus_cmd, pk(2, 0, 2, 0));
    cbus_ack = 4'b0001;
    tick;
    chk("t2_orig_ign", cbus_cmd, pk(2, 0, 2, 0));
    cbus_ack = 4'b0010;
    tick;
    chk("t2_ack1", cbus_cmd, pk(2, 0, 0, 0));
    cbus_ack = '0;
    tick;
    chk("t2_wait3", cbus_cmd, pk(2, 0, 0, 0));
    chk("t2_busy", busy, 1);
    cbus_ack = 4'b1000;
    tick;
    chk("t2_en_rd", cbus_cmd, pk(0, 0, 0, 4));
    cbus_ack = 4'b0001;
    tick;
    cbus_ack = '0;
    chk("t2_nop", cbus_cmd, 0);
    chk("t2_idle", busy, 0);
    // asynchronous reset in the middle of a snoop
    req(1, 3'd3, 32'hAA);
    req(3, 3'd4, 32'hBB);
    tick;
    chk("t6_ack", mbus_ack, 4'b1010);
    req(1, 3'd0, 32'h0);
    req(3, 3'd0, 32'h0);
    tick;
    chk("t6_snoop", cbus_cmd, pk(1, 1, 0, 1));
    chk("t6_addr", cbus_addr, 32'hAA);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_cmd", cbus_cmd, 0);
    chk("t6_rst_addr", cbus_addr, 0);
    chk("t6_rst_busy", busy, 0);
    tick;
    rst = 1'b1;
    tick;
    tick;
    tick;
    chk("t6_no_stale_busy", busy, 0);
    chk("t6_no_stale_cmd", cbus_cmd, 0);
    chk("t6_no_stale_ack", mbus_ack, 0);
    // contention from reset: grants 0,1,2 then rr=3 favours port3 over port0
    req(0, 3'd4, 32'h10);
    req(1, 3'd4, 32'h11);
    req(2, 3'd4, 32'h12);
    tick;
    chk("t3_ack", mbus_ack, 4'b0111);
    req(0, 3'd0, 32'h0);
    req(1, 3'd0, 32'h0);
    req(2, 3'd0, 32'h0);
    tick;
    chk("t3_g0", cbus_cmd, pk(2, 2, 2, 0));
    chk("t3_a0", cbus_addr, 32'h10);
    serve(0, 3'd4, "t3_0");
    tick;
    chk("t3_g1", cbus_cmd, pk(2, 2, 0, 2));
    chk("t3_a1", cbus_addr, 32'h11);
    serve(1, 3'd4, "t3_1");
    tick;
    chk("t3_g2", cbus_cmd, pk(2, 0, 2, 2));
    chk("t3_a2", cbus_addr, 32'h12);
    req(0, 3'd3, 32'h20);
    req(3, 3'd3, 32'h23);
    tick;
    chk("t3_ack_busy", mbus_ack, 4'b1001);
    req(0, 3'd0, 32'h0);
    req(3, 3'd0, 32'h0);
    serve(2, 3'd4, "t3_2");
    tick;
    chk("t3_g3", cbus_cmd, pk(0, 1, 1, 1));
    chk("t3_a3", cbus_addr, 32'h23);
    serve(3, 3'd3, "t3_3");
    tick;
    chk("t3_g0b", cbus_cmd, pk(1, 1, 1, 0));
    chk("t3_a0b", cbus_addr, 32'h20);
    serve(0, 3'd3, "t3_0b");
    // port1 holds its request through its own service
    req(1, 3'd3, 32'h30);
    tick;
    chk("t4_ack", mbus_ack, 4'b0010);
    tick;
    chk("t4_pulse", mbus_ack, 0);
    chk("t4_snoop", cbus_cmd, pk(1, 1, 0, 1));
    cbus_ack = 4'b1101;
    tick;
    chk("t4_noack_en", mbus_ack, 0);
    chk("t4_en", cbus_cmd, pk(0, 0, 3, 0));
    cbus_ack = 4'b0010;
    tick;
    cbus_ack = '0;
    chk("t4_noack_clr", mbus_ack, 0);
    chk("t4_nop", cbus_cmd, 0);
    tick;
    chk("t4_reack", mbus_ack, 4'b0010);
    tick;
    chk("t4_reack_pulse", mbus_ack, 0);
    chk("t4_regrant", cbus_cmd, pk(1, 1, 0, 1));
    req(1, 3'd0, 32'h0);
    serve(1, 3'd3, "t4");
    // non-broadcast commands are never captured
    foreach (fv[i]) begin
      mbus_cmd = {4{fv[i]}};
      tick;
      tick;
      chk("t5_ack", mbus_ack, 0);
      chk("t5_busy", busy, 0);
    end
    mbus_cmd = '0;
    tick;
    chk("t5_cmd", cbus_cmd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
